imem_ctrl: RTL
==============

Name: imem_ctrl

Overview:
- Sequences the single-port, synchronous-read instruction memory.
- Two jobs:
  - Boot/reload: streams a program image into the memory from a loader interface while the core is held.
  - Run: serves core fetch requests with a fixed 1-cycle read latency.
- Sits between the fetch stage, the program loader (UART/debug bridge) and the instruction RAM macro.

Parameters:
- WIDTH, 32, instruction/data word width
- ADD_SIZE, 32, byte-address width of fetch port
- DEPTH, 1024, memory depth in words
- IDX_W, 10, word-index width (clog2(DEPTH))
- LEN_W, 11, loader length width (must hold DEPTH)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ld_start  in  1  begin load; latches i_ld_len
- i_ld_len  in  LEN_W  words to load (0..DEPTH)
- i_ld_valid  in  1  loader word valid
- i_ld_data  in  WIDTH  loader word
- o_ld_ready  out  1  controller accepts loader word
- o_ld_done  out  1  one-cycle pulse, load complete
- i_run  in  1  release core without loading (IDLE only)
- o_core_hold  out  1  hold core PC/pipeline
- i_fetch_req  in  1  fetch request
- i_fetch_add  in  ADD_SIZE  byte address
- o_fetch_valid  out  1  o_fetch_instr valid this cycle
- o_fetch_instr  out  WIDTH  fetched instruction
- o_fetch_err  out  1  misaligned or out-of-range fetch, same cycle as valid
- o_mem_en  out  1  memory enable
- o_mem_we  out  1  memory write enable
- o_mem_idx  out  IDX_W  word index
- o_mem_wdata  out  WIDTH  write data
- i_mem_rdata  in  WIDTH  read data, valid the cycle after en&!we

Behaviour:
- States: IDLE, LOAD, RUN. Encodings go in the package.
- Reset (async, any state):
  - state=IDLE, write pointer=0, response pipeline cleared.
  - o_core_hold=1.
  - o_ld_ready, o_ld_done, o_fetch_valid, o_fetch_err, o_mem_en, o_mem_we = 0.
  - o_mem_idx=0, o_mem_wdata=0, o_fetch_instr=0.
- IDLE:
  - o_core_hold=1.
  - i_ld_start -> LOAD: latch len, ptr=0.
  - else i_run -> RUN.
  - If both are high, i_ld_start wins.
- LOAD:
  - o_core_hold=1, o_ld_ready=1.
  - Write when i_ld_valid&o_ld_ready:
    - mem_en=we=1, idx=ptr, wdata=i_ld_data (combinational drive).
    - ptr++.
  - After the write with ptr==len-1: ready drops next cycle, o_ld_done pulses for one cycle, state -> RUN.
  - len==0 at start: LOAD lasts one cycle with no writes, then done pulse and RUN.
  - len>DEPTH is clamped to DEPTH.
  - i_ld_start during LOAD restarts: ptr=0, new len, no done pulse.
- RUN:
  - o_core_hold=0.
  - Fetch with i_fetch_req=1:
    - idx=i_fetch_add>>2 (truncated to IDX_W), mem_en=1, we=0.
    - Next cycle: o_fetch_valid=1, o_fetch_instr=i_mem_rdata.
  - Back-to-back requests give one response per cycle, latency 1.
  - Misaligned (add[1:0]!=0) or add>>2 >= DEPTH:
    - No memory access.
    - Next cycle: valid=1, err=1, instr=32'h00000013 (NOP).
  - i_ld_start in RUN:
    - -> LOAD, o_core_hold=1 the same cycle (combinational from state+start).
    - A fetch that cycle is not issued.
    - Any response due the next cycle is suppressed (valid=0).
- Idle outputs: o_mem_idx/o_mem_wdata hold their last value when not enabled. Only o_mem_en/we are meaningful.

Decomposition:
- Shared package holds:
  - state typedef/localparams (IDLE/LOAD/RUN)
  - NOP_INSTR=32'h00000013
  - default WIDTH/DEPTH constants, shared with the memory macro
- One sub-module: imem_fetch_resp, the 1-cycle response register (valid/err/instr select with suppress input).
- Loader counter and FSM stay in the top level.

Test Plan:
- Reset mid-LOAD after 3 of 8 words -> all outputs at reset values, state IDLE, o_core_hold=1. A new load of 2 words writes idx 0,1.
- i_ld_start, len=4, words A0..A3 with a one-cycle valid gap after A1 -> four writes at idx 0..3. o_ld_done pulses once, the cycle after the A3 write. o_core_hold falls the following cycle.
- RUN, back-to-back fetches at 0x0, 0x4, 0x8 -> o_fetch_valid for 3 consecutive cycles, starting 1 cycle after the first request, returning A0, A1, A2 in order.
- Fetch 0x6 -> err=1, instr=0x00000013, no mem_en. Fetch 0x1000 with DEPTH=1024 -> same error response.
- RUN, i_fetch_req and i_ld_start in the same cycle -> no mem read, o_fetch_valid stays 0 the next cycle, state LOAD, o_core_hold=1 immediately.
- len=0 load -> no writes, o_ld_done after 1 cycle, RUN. IDLE with i_run=1 and i_ld_start=1 -> LOAD.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller and the RAM macro.
package imem_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 1024;

  // addi x0, x0, 0 -- returned in place of data on a faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_fetch_resp.sv
// One-cycle fetch response register: tracks whether a response is due and
// whether it is a fault, and selects memory data or NOP accordingly.
module imem_fetch_resp
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_rd,
  input  logic             issue_err,
  input  logic             suppress,
  input  logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] instr
);

  logic valid_q;
  logic err_q;

  // Capture this cycle's request outcome for presentation next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= (issue_rd | issue_err) & ~suppress;
      err_q   <= issue_err & ~suppress;
    end
  end

  // Present memory data or the NOP substitute while a response is due
  always_comb begin
    valid = valid_q;
    err   = valid_q & err_q;
    instr = '0;
    if (valid_q) begin
      instr = err_q ? WIDTH'(NOP_INSTR) : rdata;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: streams a program image in from the loader
// while the core is held, then serves core fetches with 1-cycle latency.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned ADD_SIZE = 32,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned LEN_W    = 11
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ld_start,
  input  logic [LEN_W-1:0]    i_ld_len,
  input  logic                i_ld_valid,
  input  logic [WIDTH-1:0]    i_ld_data,
  output logic                o_ld_ready,
  output logic                o_ld_done,
  input  logic                i_run,
  output logic                o_core_hold,
  input  logic                i_fetch_req,
  input  logic [ADD_SIZE-1:0] i_fetch_add,
  output logic                o_fetch_valid,
  output logic [WIDTH-1:0]    o_fetch_instr,
  output logic                o_fetch_err,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [IDX_W-1:0]    o_mem_idx,
  output logic [WIDTH-1:0]    o_mem_wdata,
  input  logic [WIDTH-1:0]    i_mem_rdata
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               fin_q, fin_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;

  logic [LEN_W-1:0]    len_in;
  logic [ADD_SIZE-1:0] word_add;
  logic                fetch_bad;
  logic                issue_rd;
  logic                issue_err;
  logic                suppress;

  // Requested length clamped to capacity; fetch fault decode
  always_comb begin
    len_in    = (i_ld_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_ld_len;
    word_add  = i_fetch_add >> 2;
    fetch_bad = (|i_fetch_add[1:0]) || (word_add >= ADD_SIZE'(DEPTH));
  end

  // State, loader counters and held memory address/data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      fin_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and output decode. fin_q marks the extra LOAD cycle that
  // carries the done pulse, so the core stays held until the cycle after it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    fin_d       = fin_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    o_core_hold = 1'b1;
    o_ld_ready  = 1'b0;
    o_ld_done   = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    issue_rd    = 1'b0;
    issue_err   = 1'b0;
    suppress    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_ld_start) begin
          state_d = ST_LOAD;
          len_d   = len_in;
          ptr_d   = '0;
          fin_d   = 1'b0;
        end else if (i_run) begin
          state_d = ST_RUN;
        end
      end

      ST_LOAD: begin
        if (i_ld_start) begin
          len_d = len_in;
          ptr_d = '0;
          fin_d = 1'b0;
        end else if (fin_q) begin
          o_ld_done = 1'b1;
          fin_d     = 1'b0;
          state_d   = ST_RUN;
        end else if (ptr_q == len_q) begin
          fin_d = 1'b1;
        end else begin
          o_ld_ready = 1'b1;
          if (i_ld_valid) begin
            o_mem_en = 1'b1;
            o_mem_we = 1'b1;
            idx_d    = ptr_q[IDX_W-1:0];
            wdata_d  = i_ld_data;
            ptr_d    = ptr_q + LEN_W'(1);
            if (ptr_q == len_q - LEN_W'(1)) begin
              fin_d = 1'b1;
            end
          end
        end
      end

      ST_RUN: begin
        o_core_hold = 1'b0;
        if (i_ld_start) begin
          o_core_hold = 1'b1;
          suppress    = 1'b1;
          state_d     = ST_LOAD;
          len_d       = len_in;
          ptr_d       = '0;
          fin_d       = 1'b0;
        end else if (i_fetch_req) begin
          if (fetch_bad) begin
            issue_err = 1'b1;
          end else begin
            issue_rd = 1'b1;
            o_mem_en = 1'b1;
            idx_d    = word_add[IDX_W-1:0];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    o_mem_idx   = idx_d;
    o_mem_wdata = wdata_d;
  end

  imem_fetch_resp #(
    .WIDTH(WIDTH)
  ) u_resp (
    .clk       (i_clk),
    .rst       (i_rst),
    .issue_rd  (issue_rd),
    .issue_err (issue_err),
    .suppress  (suppress),
    .rdata     (i_mem_rdata),
    .valid     (o_fetch_valid),
    .err       (o_fetch_err),
    .instr     (o_fetch_instr)
  );

endmodule
